// File: rtl/can_frame_rx_mopshub.sv
// CAN 2.0A bit-level receiver: samples the bus, destuffs, checks CRC-15 and frame
// form, and reports each decoded frame or abort as a one-cycle strobe.
module can_frame_rx_mopshub #(
    parameter int CLKS_PER_BIT = 10,
    parameter int SAMPLE_PT    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        frm_valid,
    output logic [10:0] frm_id,
    output logic        frm_rtr,
    output logic [3:0]  frm_dlc,
    output logic [63:0] frm_data,
    output logic        frm_ack,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic        busy
);
    // state             | meaning
    // IDLE              | waiting for 11 recessive samples;  WAIT_SOF | bus idle, hard-sync on falling edge
    // ARB/CTRL/DATA/CRC | destuffed fields;  CRC_DEL/ACK/ACK_DEL/EOF | fixed-form tail, no destuffing
    typedef enum logic [3:0] {
        IDLE, WAIT_SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF
    } state_t;

    localparam logic [7:0]  CNT_LAST   = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  CNT_SAMPLE = 8'(SAMPLE_PT);
    localparam logic [14:0] CRC_POLY   = 15'h4599;
    localparam logic [1:0]  ERR_STUFF  = 2'd0;
    localparam logic [1:0]  ERR_CRC    = 2'd1;
    localparam logic [1:0]  ERR_FORM   = 2'd2;

    state_t      state;
    logic        rx_meta, rx_sync, rx_prev;
    logic [7:0]  bit_cnt;
    logic [3:0]  idle_cnt;
    logic [6:0]  field_cnt;
    logic [6:0]  data_bits;
    logic [2:0]  run_len;
    logic        last_bit;
    logic [14:0] crc_calc, crc_rx;
    logic [10:0] id_sr;
    logic        rtr_r, ack_r;
    logic [3:0]  dlc_r;
    logic [63:0] data_sr;

    logic        hard_sync, sample, stuff_phase, is_stuff;
    logic        stuff_err, form_err, crc_err;
    logic [2:0]  run_next;
    logic [3:0]  dlc_full, n_bytes;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? CRC_POLY : 15'h0000);
    endfunction

    assign hard_sync = (state == WAIT_SOF) && rx_prev && !rx_sync;
    assign sample    = (bit_cnt == CNT_SAMPLE) && !hard_sync;

    always_comb begin
        stuff_phase = (state == ARB) || (state == CTRL) || (state == DATA) || (state == CRC);
        is_stuff    = stuff_phase && (run_len == 3'd5);
        run_next    = (rx_sync == last_bit) ? run_len + 3'd1 : 3'd1;
        stuff_err   = is_stuff && (rx_sync == last_bit);
        form_err    = (!is_stuff && (state == CTRL) && (field_cnt == 7'd0) && rx_sync)
                   || (!rx_sync && ((state == CRC_DEL) || (state == ACK_DEL) || (state == EOF)));
        crc_err     = !is_stuff && (state == CRC) && (field_cnt == 7'd14)
                   && ({crc_rx[13:0], rx_sync} != crc_calc);
        dlc_full    = {dlc_r[2:0], rx_sync};
        n_bytes     = rtr_r ? 4'd0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (hard_sync || (bit_cnt == CNT_LAST))
            bit_cnt <= '0;
        else
            bit_cnt <= bit_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idle_cnt  <= '0;
            field_cnt <= '0;
            data_bits <= '0;
            run_len   <= '0;
            last_bit  <= 1'b0;
            crc_calc  <= '0;
            crc_rx    <= '0;
            id_sr     <= '0;
            rtr_r     <= 1'b0;
            dlc_r     <= '0;
            data_sr   <= '0;
            ack_r     <= 1'b0;
            frm_valid <= 1'b0;
            frm_id    <= '0;
            frm_rtr   <= 1'b0;
            frm_dlc   <= '0;
            frm_data  <= '0;
            frm_ack   <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b0;
        end else begin
            frm_valid <= 1'b0;
            err_valid <= 1'b0;
            if (sample) begin
                if (stuff_err || form_err || crc_err) begin
                    err_valid <= 1'b1;
                    err_code  <= stuff_err ? ERR_STUFF : (form_err ? ERR_FORM : ERR_CRC);
                    busy      <= 1'b0;
                    idle_cnt  <= '0;
                    state     <= IDLE;
                end else if (is_stuff) begin
                    last_bit <= rx_sync;
                    run_len  <= 3'd1;
                    // A stuff bit may trail the last CRC bit before the delimiter.
                    if ((state == CRC) && (field_cnt == 7'd15))
                        state <= CRC_DEL;
                end else begin
                    if (stuff_phase) begin
                        last_bit <= rx_sync;
                        run_len  <= run_next;
                    end
                    case (state)
                        IDLE: begin
                            if (!rx_sync)
                                idle_cnt <= '0;
                            else if (idle_cnt == 4'd10) begin
                                idle_cnt <= '0;
                                state    <= WAIT_SOF;
                            end else
                                idle_cnt <= idle_cnt + 4'd1;
                        end
                        WAIT_SOF: begin
                            if (!rx_sync) begin
                                busy      <= 1'b1;
                                crc_calc  <= crc_step(15'h0000, 1'b0);
                                crc_rx    <= '0;
                                last_bit  <= 1'b0;
                                run_len   <= 3'd1;
                                field_cnt <= '0;
                                data_sr   <= '0;
                                ack_r     <= 1'b0;
                                state     <= ARB;
                            end
                        end
                        ARB: begin
                            crc_calc <= crc_step(crc_calc, rx_sync);
                            if (field_cnt == 7'd11) begin
                                rtr_r     <= rx_sync;
                                field_cnt <= '0;
                                state     <= CTRL;
                            end else begin
                                id_sr     <= {id_sr[9:0], rx_sync};
                                field_cnt <= field_cnt + 7'd1;
                            end
                        end
                        CTRL: begin
                            crc_calc <= crc_step(crc_calc, rx_sync);
                            if (field_cnt >= 7'd2)
                                dlc_r <= dlc_full;
                            if (field_cnt == 7'd5) begin
                                field_cnt <= '0;
                                data_bits <= {n_bytes, 3'b000};
                                state     <= (n_bytes == 4'd0) ? CRC : DATA;
                            end else
                                field_cnt <= field_cnt + 7'd1;
                        end
                        DATA: begin
                            crc_calc <= crc_step(crc_calc, rx_sync);
                            data_sr[6'd63 - field_cnt[5:0]] <= rx_sync;
                            if (field_cnt == data_bits - 7'd1) begin
                                field_cnt <= '0;
                                state     <= CRC;
                            end else
                                field_cnt <= field_cnt + 7'd1;
                        end
                        CRC: begin
                            crc_rx <= {crc_rx[13:0], rx_sync};
                            if (field_cnt == 7'd14) begin
                                if (run_next == 3'd5)
                                    field_cnt <= 7'd15;
                                else
                                    state <= CRC_DEL;
                            end else
                                field_cnt <= field_cnt + 7'd1;
                        end
                        CRC_DEL: state <= ACK;
                        ACK: begin
                            ack_r <= !rx_sync;
                            state <= ACK_DEL;
                        end
                        ACK_DEL: begin
                            field_cnt <= '0;
                            state     <= EOF;
                        end
                        EOF: begin
                            if (field_cnt == 7'd6) begin
                                frm_valid <= 1'b1;
                                frm_id    <= id_sr;
                                frm_rtr   <= rtr_r;
                                frm_dlc   <= dlc_r;
                                frm_data  <= data_sr;
                                frm_ack   <= ack_r;
                                busy      <= 1'b0;
                                state     <= WAIT_SOF;
                            end else
                                field_cnt <= field_cnt + 7'd1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
